m68k_bus_master: RTL and testbench
==================================

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 Parameter ADDR_W, default 24: bus address width; address bits [ADDR_W-1:1] driven, A0 internal only.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before self-generated bus error, range 1..65535.
REQ-003 Parameter SYNC_STAGES, default 2: flop depth of the synchroniser on DTACK_n/BERR_n/VPA_n/HALT_n, range 1..3.
REQ-004 Parameter RETRY_MAX, default 3: maximum reruns on BERR_n+HALT_n.
REQ-005 The clock port SHALL be C100 (input, 1, bus clock); all state changes occur on its rising edge.
REQ-006 The reset port SHALL be P_RESET_n (input, 1, asynchronous active-low reset).
REQ-007 The request port SHALL comprise the following signals:
- req_valid (in, 1)
- req_ready (out, 1)
- req_addr (in, ADDR_W)
- req_wdata (in, 16)
- req_rw (in, 1; 1 = read)
- req_byte (in, 1; 1 = byte, 0 = word)
- req_fc (in, 3)
REQ-008 The response port SHALL comprise the following signals:
- rsp_valid (out, 1; one-cycle pulse)
- rsp_rdata (out, 16)
- rsp_err (out, 1)
- rsp_timeout (out, 1)
- rsp_vpa (out, 1)
REQ-009 The bus port SHALL comprise the following signals:
- P_A (out, ADDR_W-1)
- P_FC (out, 3)
- P_D_out (out, 16)
- P_D_oe (out, 1)
- P_D_in (in, 16)
- P_AS_n / P_UDS_n / P_LDS_n / P_RW_n (out, 1 each)
- P_DTACK_n / P_BERR_n / P_VPA_n / P_HALT_n (in, 1 each)

Function
REQ-010 States SHALL be IDLE, ADDR, ASSERT, WAIT, LATCH, END, RERUN.
REQ-011 IDLE: req_ready=1; when req_valid=1, the block SHALL latch all req_* fields and go to ADDR; otherwise it stays in IDLE.
REQ-012 req_ready SHALL be 0 in every state except IDLE; req_valid outside IDLE is ignored.
REQ-013 ADDR (1 cycle): drive P_A=addr[ADDR_W-1:1], P_FC, and P_RW_n=rw; strobes stay negated. For a write, also drive P_D_oe=1 and P_D_out.
REQ-014 Write data SHALL be req_wdata for word writes, and {wdata[7:0],wdata[7:0]} for byte writes.
REQ-015 ASSERT (1 cycle): P_AS_n=0. For a read, data strobes SHALL also assert this cycle; for a write, data strobes SHALL assert on entry to WAIT.
REQ-016 Data strobe selection: word asserts UDS_n and LDS_n; byte with A0=0 asserts UDS_n only; byte with A0=1 asserts LDS_n only.
REQ-017 WAIT: a 16-bit counter SHALL start at 0 on entry and increment each cycle. The synchronised inputs are evaluated each cycle in this priority:
- BERR=0 and HALT=0 -> RERUN.
- BERR=0 -> END with err=1.
- DTACK=0 or VPA=0 -> LATCH, with vpa=!VPA.
- counter==TIMEOUT-1 -> END with err=1 and timeout=1.
REQ-018 LATCH (1 cycle): capture P_D_in into rsp_rdata on entry (reads only), negate all strobes, and set P_D_oe=0.
REQ-019 END: strobes SHALL be negated and P_D_oe=0; rsp_valid SHALL pulse for exactly the first cycle of END.
REQ-020 END SHALL return to IDLE only when synchronised DTACK_n, BERR_n and VPA_n are all 1.
REQ-021 rsp_err, rsp_timeout, rsp_vpa and rsp_rdata SHALL hold their values until the next rsp_valid.
REQ-022 RERUN: strobes negated; the retry count increments on entry. The block waits for synchronised HALT_n=1 and BERR_n=1, then re-enters ADDR with the same latched request.
REQ-023 If the retry count exceeds RETRY_MAX, the block SHALL go to END with err=1 instead of ADDR.
REQ-024 The retry count SHALL clear on IDLE->ADDR.
REQ-025 If DTACK and BERR are asserted in the same sample, BERR SHALL take priority.
REQ-026 With SYNC_STAGES=2 and DTACK_n driven low combinationally from P_AS_n, rsp_valid SHALL go high after the 5th rising edge following the accept edge.

Reset
REQ-027 While P_RESET_n=0, the block SHALL go to IDLE immediately and asynchronously.
REQ-028 Outputs under reset SHALL be:
- P_AS_n, P_UDS_n, P_LDS_n, P_RW_n = 1
- P_D_oe = 0
- P_A, P_FC, P_D_out = 0
- req_ready = 0
- rsp_valid, rsp_err, rsp_timeout, rsp_vpa = 0
- rsp_rdata = 0
- counter and retry count = 0
REQ-029 When reset is released, req_ready SHALL become 1 after the first rising edge.
REQ-030 A reset during any bus cycle SHALL abort that cycle with no rsp_valid.

Verification
REQ-031 Word read of addr 0x000100 with DTACK tied to AS and P_D_in=0xBEEF -> rsp_valid 5 edges after accept; rdata=0xBEEF; err=0; UDS_n=LDS_n=0 during strobes.
REQ-032 Byte write of addr 0x000101 with wdata=0x00A5 -> P_D_out=0xA5A5; only LDS_n asserted; P_RW_n=0 from ADDR onward; DS asserts one cycle after AS; rsp_err=0.
REQ-033 Read with no DTACK and TIMEOUT=8 -> rsp_valid with err=1 and timeout=1; exactly 8 WAIT cycles; AS_n negated before rsp_valid.
REQ-034 BERR_n+HALT_n asserted on every attempt with RETRY_MAX=3 -> 4 AS_n assertions total, then err=1, timeout=0. Separately, a rerun followed by DTACK on the 2nd attempt -> err=0 with correct data.
REQ-035 DTACK_n and BERR_n asserted in the same cycle -> err=1 and rdata unchanged. VPA_n alone -> rsp_vpa=1, err=0.
REQ-036 P_RESET_n pulsed low while in WAIT -> strobes negate without a clock edge; no rsp_valid; a new request after release completes normally.

Source files
------------

// File: rtl/m68k_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_bus_master
//  Purpose  : Single-transfer 68000-style asynchronous bus master. Accepts one
//             request at a time, runs the AS/UDS/LDS handshake, waits for a
//             synchronised DTACK/VPA, handles bus error, rerun (BERR+HALT) and
//             self-timed timeout, and returns a one-cycle response pulse.
//  Ports    : C100 / P_RESET_n       clock, asynchronous active-low reset
//             req_*                  request handshake (accepted in IDLE)
//             rsp_*                  response (rsp_valid pulses, rest held)
//             P_*                    68k bus pins (strobes active-low)
//  Revision : 1.0  initial release
// ============================================================================
module m68k_bus_master #(
    parameter int ADDR_W      = 24,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2,
    parameter int RETRY_MAX   = 3
) (
    input  logic              C100,
    input  logic              P_RESET_n,
    // request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic              req_rw,
    input  logic              req_byte,
    input  logic [2:0]        req_fc,
    // response
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              rsp_vpa,
    // bus
    output logic [ADDR_W-2:0] P_A,
    output logic [2:0]        P_FC,
    output logic [15:0]       P_D_out,
    output logic              P_D_oe,
    input  logic [15:0]       P_D_in,
    output logic              P_AS_n,
    output logic              P_UDS_n,
    output logic              P_LDS_n,
    output logic              P_RW_n,
    input  logic              P_DTACK_n,
    input  logic              P_BERR_n,
    input  logic              P_VPA_n,
    input  logic              P_HALT_n
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ASSERT = 3'd2,
        S_WAIT   = 3'd3,
        S_LATCH  = 3'd4,
        S_END    = 3'd5,
        S_RERUN  = 3'd6
    } state_t;

    // Retry counter must be able to hold RETRY_MAX+1 (the "exceeded" value).
    localparam int             RCW         = $clog2(RETRY_MAX + 2);
    localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(RETRY_MAX);
    localparam logic [15:0]    WAIT_LAST   = 16'(TIMEOUT - 1);

    state_t state, state_nxt;

    logic              run_q;       // low only until the first edge after reset
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       dout_q;
    logic              rw_q;
    logic              byte_q;
    logic [2:0]        fc_q;
    logic [15:0]       cnt_q;
    logic [RCW-1:0]    retry_q;
    logic              vpa_q;
    logic              end_err;
    logic              end_to;

    // ------------------------------------------------------------------
    // Input synchronisers, reset to the negated (high) level.
    // Bit order: {DTACK_n, BERR_n, VPA_n, HALT_n}.
    // ------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_STAGES];
    logic       dtack_n_s, berr_n_s, vpa_n_s, halt_n_s;

    always_ff @(posedge C100 or negedge P_RESET_n) begin
        if (!P_RESET_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'hF;
            end
        end else begin
            sync_q[0] <= {P_DTACK_n, P_BERR_n, P_VPA_n, P_HALT_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign {dtack_n_s, berr_n_s, vpa_n_s, halt_n_s} = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Next-state logic. end_err/end_to only matter on the edge into END.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        end_err   = 1'b0;
        end_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && run_q) state_nxt = S_ADDR;
            end
            S_ADDR:   state_nxt = S_ASSERT;
            S_ASSERT: state_nxt = S_WAIT;
            S_WAIT: begin
                // BERR outranks DTACK/VPA sampled in the same cycle.
                if (!berr_n_s && !halt_n_s) begin
                    state_nxt = S_RERUN;
                end else if (!berr_n_s) begin
                    state_nxt = S_END;
                    end_err   = 1'b1;
                end else if (!dtack_n_s || !vpa_n_s) begin
                    state_nxt = S_LATCH;
                end else if (cnt_q == WAIT_LAST) begin
                    state_nxt = S_END;
                    end_err   = 1'b1;
                    end_to    = 1'b1;
                end
            end
            S_LATCH: state_nxt = S_END;
            S_END: begin
                // Hold until the slave has released all its handshake lines.
                if (dtack_n_s && berr_n_s && vpa_n_s) state_nxt = S_IDLE;
            end
            S_RERUN: begin
                if (halt_n_s && berr_n_s) begin
                    if (retry_q > RETRY_LIMIT) begin
                        state_nxt = S_END;
                        end_err   = 1'b1;
                    end else begin
                        state_nxt = S_ADDR;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge C100 or negedge P_RESET_n) begin
        if (!P_RESET_n) begin
            state       <= S_IDLE;
            run_q       <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rw_q        <= 1'b1;
            byte_q      <= 1'b0;
            fc_q        <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            vpa_q       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_vpa     <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_q     <= 1'b1;
            rsp_valid <= 1'b0;

            if (state == S_IDLE && state_nxt == S_ADDR) begin
                addr_q  <= req_addr;
                dout_q  <= req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
                rw_q    <= req_rw;
                byte_q  <= req_byte;
                fc_q    <= req_fc;
                retry_q <= '0;
            end

            // Counts cycles spent in WAIT; zero on every WAIT entry.
            cnt_q <= (state == S_WAIT) ? cnt_q + 16'd1 : 16'd0;

            if (state_nxt == S_RERUN && state != S_RERUN) begin
                retry_q <= retry_q + 1'b1;
            end

            // Data is sampled while the strobes are still asserted.
            if (state == S_WAIT && state_nxt == S_LATCH) begin
                vpa_q <= !vpa_n_s;
                if (rw_q) rsp_rdata <= P_D_in;
            end

            if (state_nxt == S_END && state != S_END) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= end_err;
                rsp_timeout <= end_to;
                rsp_vpa     <= (state == S_LATCH) ? vpa_q : 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs decoded from state. Write strobes lag AS by one cycle so
    // data is stable before the slave sees DS.
    // ------------------------------------------------------------------
    logic as_on, ds_on;

    assign as_on = (state == S_ASSERT) || (state == S_WAIT);
    assign ds_on = rw_q ? as_on : (state == S_WAIT);

    assign req_ready = (state == S_IDLE) && run_q;
    assign P_AS_n    = !as_on;
    assign P_UDS_n   = !(ds_on && (!byte_q || !addr_q[0]));
    assign P_LDS_n   = !(ds_on && (!byte_q ||  addr_q[0]));
    assign P_RW_n    = (state == S_IDLE) ? 1'b1 : rw_q;
    assign P_D_oe    = !rw_q && ((state == S_ADDR) || (state == S_ASSERT) || (state == S_WAIT));
    assign P_A       = addr_q[ADDR_W-1:1];
    assign P_FC      = fc_q;
    assign P_D_out   = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m68k_bus_master
//  Purpose  : Self-checking bench for m68k_bus_master. A behavioural slave
//             answers each transfer in a chosen mode; expected responses are
//             queued at issue time and compared by a monitor on rsp_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m68k_bus_master;

    localparam int TIMEOUT   = 8;
    localparam int RETRY_MAX = 3;

    // slave behaviours
    localparam int M_DTACK   = 0;
    localparam int M_VPA     = 1;
    localparam int M_NONE    = 2;
    localparam int M_BERR    = 3;
    localparam int M_RR_ALL  = 4;
    localparam int M_RR_ONCE = 5;
    localparam int M_BOTH    = 6;

    logic        C100 = 1'b0;
    logic        P_RESET_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_rw = 1'b1;
    logic        req_byte = 1'b0;
    logic [2:0]  req_fc = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, rsp_vpa;
    logic [22:0] P_A;
    logic [2:0]  P_FC;
    logic [15:0] P_D_out;
    logic        P_D_oe;
    logic [15:0] P_D_in = '0;
    logic        P_AS_n, P_UDS_n, P_LDS_n, P_RW_n;
    logic        P_DTACK_n, P_BERR_n, P_VPA_n, P_HALT_n;

    m68k_bus_master #(
        .ADDR_W(24), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2), .RETRY_MAX(RETRY_MAX)
    ) dut (
        .C100(C100), .P_RESET_n(P_RESET_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .req_byte(req_byte), .req_fc(req_fc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .rsp_vpa(rsp_vpa),
        .P_A(P_A), .P_FC(P_FC), .P_D_out(P_D_out), .P_D_oe(P_D_oe), .P_D_in(P_D_in),
        .P_AS_n(P_AS_n), .P_UDS_n(P_UDS_n), .P_LDS_n(P_LDS_n), .P_RW_n(P_RW_n),
        .P_DTACK_n(P_DTACK_n), .P_BERR_n(P_BERR_n), .P_VPA_n(P_VPA_n), .P_HALT_n(P_HALT_n)
    );

    always #5 C100 = ~C100;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural slave: responds combinationally from AS_n.
    // ------------------------------------------------------------------
    int mode       = M_DTACK;
    int as_falls   = 0;
    int base_falls = 0;

    always @(negedge P_AS_n) as_falls++;

    always_comb begin
        logic as_on;
        int   att;
        as_on     = (P_AS_n === 1'b0);
        att       = as_falls - base_falls;
        P_DTACK_n = 1'b1;
        P_BERR_n  = 1'b1;
        P_VPA_n   = 1'b1;
        P_HALT_n  = 1'b1;
        case (mode)
            M_DTACK: P_DTACK_n = !as_on;
            M_VPA:   P_VPA_n   = !as_on;
            M_BERR:  P_BERR_n  = !as_on;
            M_RR_ALL: begin
                P_BERR_n = !as_on;
                P_HALT_n = !as_on;
            end
            M_RR_ONCE: begin
                if (att <= 1) begin
                    P_BERR_n = !as_on;
                    P_HALT_n = !as_on;
                end else begin
                    P_DTACK_n = !as_on;
                end
            end
            M_BOTH: begin
                P_DTACK_n = !as_on;
                P_BERR_n  = !as_on;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic        err, to, vpa;
        logic [15:0] rdata;
        int          lat;       // -1: not checked
        int          ascnt;
        logic        uds, lds, rw, ds_first;
        logic [15:0] dout;
        logic [22:0] a;
        logic [2:0]  fc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_rdata = 16'h0000;

    function automatic exp_t model(input logic [23:0] a, input logic [15:0] wd, input logic rw,
                                   input logic byt, input logic [2:0] fc, input int md,
                                   input logic [15:0] din);
        exp_t e;
        e.a        = a[23:1];
        e.fc       = fc;
        e.rw       = rw;
        e.uds      = !byt || !a[0];
        e.lds      = !byt || a[0];
        e.dout     = byt ? {wd[7:0], wd[7:0]} : wd;
        e.ds_first = rw;             // read strobes come with AS, write strobes a cycle later
        e.err = 1'b0; e.to = 1'b0; e.vpa = 1'b0; e.ascnt = 1; e.lat = -1;
        case (md)
            M_DTACK:   e.lat = 5;
            M_VPA:     begin e.vpa = 1'b1; e.lat = 5; end
            M_NONE:    begin e.err = 1'b1; e.to = 1'b1; e.lat = 2 + TIMEOUT; end
            M_BERR:    e.err = 1'b1;
            M_BOTH:    e.err = 1'b1;
            M_RR_ALL:  begin e.err = 1'b1; e.ascnt = RETRY_MAX + 1; end
            M_RR_ONCE: e.ascnt = 2;
            default: ;
        endcase
        if (!e.err && rw) model_rdata = din;
        e.rdata = model_rdata;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Bus observer + response monitor (negedge sampling)
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          acc_cyc = 0;
    int          as_cnt = 0;
    logic        prev_as = 1'b1, prev_rsp = 1'b0;
    logic        uds_seen = 0, lds_seen = 0, ds_first = 0, stable_bad = 0, oe_bad = 0;
    logic [22:0] obs_a = '0;
    logic [2:0]  obs_fc = '0;
    logic        obs_rw = 1'b1;
    logic [15:0] obs_dout = '0;
    exp_t        cur;

    always @(posedge C100) cyc++;

    always @(negedge C100) begin
        if (P_RESET_n === 1'b1) begin
            if (prev_rsp) check("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
            if (req_valid && req_ready) begin
                acc_cyc = cyc; as_cnt = 0; uds_seen = 0; lds_seen = 0;
                ds_first = 0; stable_bad = 0; oe_bad = 0; obs_dout = 'x;
            end
            if (P_AS_n === 1'b0) begin
                if (prev_as) begin
                    as_cnt++;
                    if (as_cnt == 1) begin
                        ds_first = !P_UDS_n || !P_LDS_n;
                        obs_a = P_A; obs_fc = P_FC; obs_rw = P_RW_n;
                    end
                end
                if (P_A !== obs_a || P_FC !== obs_fc || P_RW_n !== obs_rw) stable_bad = 1;
                if (!P_UDS_n) uds_seen = 1;
                if (!P_LDS_n) lds_seen = 1;
                if ((!P_UDS_n || !P_LDS_n) && !P_RW_n) begin
                    obs_dout = P_D_out;
                    if (P_D_oe !== 1'b1) oe_bad = 1;
                end
                if (P_RW_n && P_D_oe) oe_bad = 1;
            end
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    check("rsp_err",     {31'd0, rsp_err},     {31'd0, cur.err});
                    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, cur.to});
                    check("rsp_vpa",     {31'd0, rsp_vpa},     {31'd0, cur.vpa});
                    check("rsp_rdata",   {16'd0, rsp_rdata},   {16'd0, cur.rdata});
                    check("as_count",    as_cnt,               cur.ascnt);
                    check("ds_select",   {30'd0, uds_seen, lds_seen}, {30'd0, cur.uds, cur.lds});
                    check("ds_timing",   {31'd0, ds_first},    {31'd0, cur.ds_first});
                    check("addr_fc_rw",  {5'd0, obs_a, obs_fc, obs_rw}, {5'd0, cur.a, cur.fc, cur.rw});
                    check("bus_stable",  {31'd0, stable_bad},  32'd0);
                    check("data_oe",     {31'd0, oe_bad},      32'd0);
                    if (!cur.rw) check("wr_data", {16'd0, obs_dout}, {16'd0, cur.dout});
                    if (cur.lat >= 0) check("latency", cyc - acc_cyc - 1, cur.lat);
                    check("bus_idle_at_rsp", {28'd0, P_AS_n, P_UDS_n, P_LDS_n, P_D_oe}, 32'hE);
                end
            end
        end
        prev_as  = P_AS_n;
        prev_rsp = (P_RESET_n === 1'b1) && (rsp_valid === 1'b1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 400) begin
            @(posedge C100); #1;
            n++;
        end
        if (req_ready !== 1'b1) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [23:0] a, input logic [15:0] wd, input logic rw,
                         input logic byt, input logic [2:0] fc, input int md,
                         input logic [15:0] din, input bit push);
        exp_t e;
        wait_ready();
        mode       = md;
        P_D_in     = din;
        base_falls = as_falls;
        req_addr = a; req_wdata = wd; req_rw = rw; req_byte = byt; req_fc = fc;
        req_valid  = 1'b1;
        @(posedge C100); #1;
        req_valid  = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;   // later changes must not matter
        if (push) begin
            e = model(a, wd, rw, byt, fc, md, din);
            exp_q.push_back(e);
        end
    endtask

    logic [23:0] r_a;
    logic [15:0] r_wd, r_din;
    logic        r_rw, r_byte;
    logic [2:0]  r_fc;
    int          r_md;

    initial begin
        // reset state
        #3;
        check("rst_strobes_rw", {28'd0, P_AS_n, P_UDS_n, P_LDS_n, P_RW_n}, 32'hF);
        check("rst_bus_drive",  {P_A, P_FC, P_D_oe}, 32'd0);
        check("rst_dout",       {16'd0, P_D_out}, 32'd0);
        check("rst_ready",      {31'd0, req_ready}, 32'd0);
        check("rst_rsp", {11'd0, rsp_valid, rsp_err, rsp_timeout, rsp_vpa, rsp_rdata}, 32'd0);
        @(posedge C100); @(posedge C100); #2;
        P_RESET_n = 1'b1;
        #1 check("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(posedge C100); #1;
        check("ready_after_edge", {31'd0, req_ready}, 32'd1);

        // directed transfers
        issue(24'h000100, 16'h0000, 1'b1, 1'b0, 3'd5, M_DTACK,   16'hBEEF, 1'b1);
        issue(24'h000101, 16'h00A5, 1'b0, 1'b1, 3'd1, M_DTACK,   16'h1234, 1'b1);
        issue(24'h000200, 16'h0000, 1'b1, 1'b0, 3'd6, M_NONE,    16'h4321, 1'b1);
        issue(24'h000300, 16'h0000, 1'b1, 1'b0, 3'd2, M_RR_ALL,  16'h1111, 1'b1);
        issue(24'h000400, 16'h0000, 1'b1, 1'b0, 3'd2, M_RR_ONCE, 16'h5A5A, 1'b1);
        issue(24'h000500, 16'h0000, 1'b1, 1'b0, 3'd5, M_BOTH,    16'hDEAD, 1'b1);
        issue(24'h000600, 16'h0000, 1'b1, 1'b1, 3'd7, M_VPA,     16'h7777, 1'b1);
        issue(24'h000702, 16'hC3C3, 1'b0, 1'b0, 3'd1, M_BERR,    16'h0000, 1'b1);

        // reset while waiting on the bus
        issue(24'h000800, 16'h0000, 1'b1, 1'b0, 3'd5, M_NONE, 16'h9999, 1'b0);
        @(posedge C100); #1; @(posedge C100); #1; @(posedge C100); #1;
        check("abort_in_wait", {31'd0, P_AS_n}, 32'd0);
        #3 P_RESET_n = 1'b0;
        #1;
        check("abort_strobes", {29'd0, P_AS_n, P_UDS_n, P_LDS_n}, 32'h7);
        check("abort_no_rsp",  {30'd0, rsp_valid, req_ready}, 32'd0);
        @(posedge C100); @(posedge C100); #2;
        P_RESET_n = 1'b1;
        @(posedge C100); #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        model_rdata = 16'h0000;   // reset cleared the held read data
        issue(24'h000900, 16'h0000, 1'b1, 1'b0, 3'd5, M_DTACK, 16'hCAFE, 1'b1);

        // randomized transfers
        for (int k = 0; k < 40; k++) begin
            r_a    = 24'($urandom);
            r_wd   = 16'($urandom);
            r_din  = 16'($urandom);
            r_rw   = 1'($urandom);
            r_byte = 1'($urandom);
            r_fc   = 3'($urandom);
            r_md   = int'($urandom_range(0, 6));
            issue(r_a, r_wd, r_rw, r_byte, r_fc, r_md, r_din, 1'b1);
        end

        wait_ready();
        repeat (3) @(posedge C100);
        #1 check("all_responses_seen", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, %0d of %0d checks failed so far", n_fail, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
